// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/response bus between the MEM stage and the memory.
// The master issues req/addr/wdata/be; the slave returns gnt, rvalid and rdata.
interface mem_stage_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic [7:0]  dm_be;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [63:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata
    );
    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: runs one data-memory access per load/store, stalls the pipe while it is
// outstanding, zero-extends load data and loads the MEM/WB register.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          aluMem,
    input  logic [63:0]          dataInMem,
    input  logic [4:0]           rdMem,
    input  logic                 reg_wr_mem,
    input  logic                 mem_wr_mem,
    input  logic                 mem_rd_mem,
    input  logic                 ldurb_mem,
    input  logic [3:0]           transfer_mem,
    mem_stage_ctrl_if.master     dm,
    output logic                 stall_mem,
    output logic                 mem_err,
    output logic [63:0]          resWb,
    output logic [4:0]           rdWb,
    output logic                 reg_wr_wb
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            to_q, to_d;
    logic [63:0]     rdata_q;
    logic [3:0]      size;
    logic            size_bad;
    logic [7:0]      be;
    logic [7:0][7:0] mask;
    logic            is_mem, is_ld, expired;

    assign is_mem  = mem_rd_mem | mem_wr_mem;
    assign is_ld   = mem_rd_mem & ~mem_wr_mem;
    assign expired = (cnt_q == CW'(TIMEOUT - 1));
    assign size    = ldurb_mem ? 4'd1 : transfer_mem;

    // Illegal sizes fall back to a full doubleword access.
    always_comb begin
        size_bad = 1'b0;
        case (size)
            4'd1:    be = 8'h01;
            4'd2:    be = 8'h03;
            4'd4:    be = 8'h0F;
            4'd8:    be = 8'hFF;
            default: begin be = 8'hFF; size_bad = 1'b1; end
        endcase
    end

    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign mask[i] = {8{be[i]}};
    end

    assign dm.dm_we    = mem_wr_mem;
    assign dm.dm_addr  = aluMem;
    assign dm.dm_wdata = dataInMem;
    assign dm.dm_be    = be;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Grant wins over an expiring watchdog in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (is_mem) begin
                state_d = REQ;
                cnt_d   = '0;
                to_d    = 1'b0;
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (dm.dm_gnt)    state_d = mem_wr_mem ? DONE : RESP;
                else if (expired) begin state_d = DONE; to_d = 1'b1; end
            end
            RESP: begin
                cnt_d = cnt_q + CW'(1);
                if (dm.dm_rvalid) state_d = DONE;
                else if (expired) begin state_d = DONE; to_d = 1'b1; end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dm.dm_req = ~reset & (state_q == REQ);
        stall_mem = ~reset & (((state_q == IDLE) & is_mem) | (state_q == REQ) | (state_q == RESP));
        mem_err   = ~reset & (state_q == DONE) & (to_q | size_bad);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            resWb     <= '0;
            rdWb      <= '0;
            reg_wr_wb <= 1'b0;
        end else begin
            if ((state_q == RESP) && dm.dm_rvalid)
                rdata_q <= dm.dm_rdata & mask;
            if (stall_mem) begin
                resWb     <= '0;
                rdWb      <= '0;
                reg_wr_wb <= 1'b0;
            end else if ((state_q == DONE) && to_q) begin
                resWb     <= '0;
                rdWb      <= rdMem;
                reg_wr_wb <= 1'b0;
            end else begin
                resWb     <= ((state_q == DONE) && is_ld) ? rdata_q : aluMem;
                rdWb      <= rdMem;
                reg_wr_wb <= reg_wr_mem & (rdMem != 5'd31);
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: pass-through, loads, stores, sizes, watchdog, reset.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] aluMem, dataInMem;
    logic [4:0]  rdMem;
    logic        reg_wr_mem, mem_wr_mem, mem_rd_mem, ldurb_mem;
    logic [3:0]  transfer_mem;
    logic        stall_mem, mem_err, reg_wr_wb;
    logic [63:0] resWb;
    logic [4:0]  rdWb;
    logic        t_stall, t_err, t_wr;
    logic [63:0] t_res;
    logic [4:0]  t_rd;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_stage_ctrl_if bus ();
    mem_stage_ctrl_if tbus ();

    mem_stage_ctrl dut (
        .clk(clk), .reset(reset), .aluMem(aluMem), .dataInMem(dataInMem), .rdMem(rdMem),
        .reg_wr_mem(reg_wr_mem), .mem_wr_mem(mem_wr_mem), .mem_rd_mem(mem_rd_mem),
        .ldurb_mem(ldurb_mem), .transfer_mem(transfer_mem), .dm(bus.master),
        .stall_mem(stall_mem), .mem_err(mem_err), .resWb(resWb), .rdWb(rdWb),
        .reg_wr_wb(reg_wr_wb)
    );

    // Short-watchdog copy; its memory never answers.
    mem_stage_ctrl #(.TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset), .aluMem(aluMem), .dataInMem(dataInMem), .rdMem(rdMem),
        .reg_wr_mem(reg_wr_mem), .mem_wr_mem(mem_wr_mem), .mem_rd_mem(mem_rd_mem),
        .ldurb_mem(ldurb_mem), .transfer_mem(transfer_mem), .dm(tbus.master),
        .stall_mem(t_stall), .mem_err(t_err), .resWb(t_res), .rdWb(t_rd),
        .reg_wr_wb(t_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rd,
                          input logic rw, input logic wr, input logic rdo, input logic ldb,
                          input logic [3:0] xf);
        aluMem = alu; dataInMem = wd; rdMem = rd; reg_wr_mem = rw;
        mem_wr_mem = wr; mem_rd_mem = rdo; ldurb_mem = ldb; transfer_mem = xf;
    endtask

    task automatic clr_op();
        set_op(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // One access: gnt after gdly idle REQ cycles, rvalid in the first RESP cycle.
    task automatic mem_op(input string tag, input logic wr, input logic rdo, input logic ldb,
                          input logic [3:0] xf, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] rdat, input logic [4:0] rd, input logic rw,
                          input int gdly, input logic [7:0] ebe, input logic [63:0] eres,
                          input logic ewr, input logic eerr);
        int stalls = 0;
        set_op(addr, wd, rd, rw, wr, rdo, ldb, xf);
        #1;
        chk({tag, "_idle_stall"}, stall_mem, 1);
        chk({tag, "_idle_req"}, bus.dm_req, 0);
        stalls += stall_mem;
        step();
        for (int i = 0; i <= gdly; i++) begin
            bus.dm_gnt = (i == gdly);
            #1;
            chk({tag, "_req"}, bus.dm_req, 1);
            chk({tag, "_addr"}, bus.dm_addr, addr);
            chk({tag, "_wdata"}, bus.dm_wdata, wd);
            chk({tag, "_be"}, bus.dm_be, ebe);
            chk({tag, "_we"}, bus.dm_we, wr);
            stalls += stall_mem;
            step();
        end
        bus.dm_gnt = 1'b0;
        if (rdo && !wr) begin
            chk({tag, "_resp_req"}, bus.dm_req, 0);
            stalls += stall_mem;
            bus.dm_rvalid = 1'b1;
            bus.dm_rdata = rdat;
            step();
            bus.dm_rvalid = 1'b0;
            bus.dm_rdata = 64'h0;
        end
        chk({tag, "_done_stall"}, stall_mem, 0);
        chk({tag, "_done_err"}, mem_err, eerr);
        chk({tag, "_done_wr"}, reg_wr_wb, 0);
        chk({tag, "_stalls"}, stalls, (rdo && !wr) ? 3 + gdly : 2 + gdly);
        step();
        clr_op();
        #1;
        chk({tag, "_err_pulse"}, mem_err, 0);
        chk({tag, "_res"}, resWb, eres);
        chk({tag, "_rd"}, rdWb, rd);
        chk({tag, "_wr"}, reg_wr_wb, ewr);
    endtask

    initial begin
        reset = 1'b1;
        clr_op();
        bus.dm_gnt = 0; bus.dm_rvalid = 0; bus.dm_rdata = 0;
        tbus.dm_gnt = 0; tbus.dm_rvalid = 0; tbus.dm_rdata = 0;
        step(); step();
        chk("rst_res", resWb, 0);
        chk("rst_rd", rdWb, 0);
        chk("rst_wr", reg_wr_wb, 0);
        chk("rst_stall", stall_mem, 0);
        chk("rst_req", bus.dm_req, 0);
        chk("rst_err", mem_err, 0);
        reset = 1'b0;

        set_op(64'h1234, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
        #1;
        chk("add_stall", stall_mem, 0);
        step();
        chk("add_res", resWb, 64'h1234);
        chk("add_rd", rdWb, 3);
        chk("add_wr", reg_wr_wb, 1);
        set_op(64'h55, 64'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 4'd8);
        step();
        chk("xzr_res", resWb, 64'h55);
        chk("xzr_wr", reg_wr_wb, 0);

        mem_op("ldur8", 0, 1, 0, 4'd8, 64'h40, 64'h0, 64'hDEADBEEF_CAFEF00D, 5'd5, 1, 0,
               8'hFF, 64'hDEADBEEF_CAFEF00D, 1, 0);
        mem_op("ldurb", 0, 1, 1, 4'd8, 64'h48, 64'h0, 64'hFFFF_FFFF_FFFF_FF9A, 5'd6, 1, 0,
               8'h01, 64'h9A, 1, 0);
        mem_op("ldh", 0, 1, 0, 4'd2, 64'h50, 64'h0, 64'h1111_2222_ABCD_1234, 5'd7, 1, 1,
               8'h03, 64'h1234, 1, 0);
        mem_op("stur4", 1, 0, 0, 4'd4, 64'h80, 64'hA5A5_5A5A_0123_4567, 64'h0, 5'd9, 0, 5,
               8'h0F, 64'h80, 0, 0);
        mem_op("ld_bad", 0, 1, 0, 4'd3, 64'h60, 64'h0, 64'h8765_4321_0FED_CBA9, 5'd4, 1, 0,
               8'hFF, 64'h8765_4321_0FED_CBA9, 1, 1);
        mem_op("rdwr", 1, 1, 0, 4'd8, 64'h70, 64'h77, 64'h0, 5'd8, 0, 0,
               8'hFF, 64'h70, 0, 0);
        mem_op("ld_x31", 0, 1, 0, 4'd4, 64'h90, 64'h0, 64'hFFFF_FFFF_8000_0001, 5'd31, 1, 0,
               8'h0F, 64'h8000_0001, 0, 0);

        set_op(64'hA0, 64'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        step();
        bus.dm_gnt = 1'b1;
        step();
        bus.dm_gnt = 1'b0;
        chk("rst_resp_stall", stall_mem, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        clr_op();
        #1;
        chk("rst_resp_req", bus.dm_req, 0);
        chk("rst_resp_stall0", stall_mem, 0);
        chk("rst_resp_wr", reg_wr_wb, 0);
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata = 64'h1;
        step();
        bus.dm_rvalid = 1'b0;
        chk("rst_resp_idle_res", resWb, 0);
        chk("rst_resp_idle_wr", reg_wr_wb, 0);
        chk("rst_resp_idle_err", mem_err, 0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        set_op(64'hC0, 64'h0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
        #1;
        chk("to_idle_stall", t_stall, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("to_req", tbus.dm_req, 1);
            chk("to_no_err", t_err, 0);
            step();
        end
        chk("to_err", t_err, 1);
        chk("to_done_req", tbus.dm_req, 0);
        chk("to_done_stall", t_stall, 0);
        step();
        clr_op();
        #1;
        chk("to_err_pulse", t_err, 0);
        chk("to_res", t_res, 0);
        chk("to_wr", t_wr, 0);
        chk("to_idle", t_stall, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
